// File: rtl/bcd_display_driver.sv
// bcd_display_driver: Avalon-MM slave that converts a 16-bit binary VALUE to
// packed BCD with a sequential double-dabble engine and drives a 4-digit
// multiplexed, active-low 7-segment display.
// Optional build macro: BCD_DISPLAY_BLANK_EN blanks leading zero digits
// (digit 0 always shows); left undefined, all four digits always show.
module bcd_display_driver #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned DIGITS   = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [6:0]        seg_n,
   output logic [DIGITS-1:0] dig_n,
   output logic [1:0]        status
);

   localparam int unsigned CNT_W     = $clog2(SCAN_DIV);
   localparam int unsigned DIG_IDX_W = $clog2(DIGITS);
   localparam int unsigned ACC_W     = 20;
   localparam int unsigned BIN_W     = 16;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]           state_q;
   logic [1:0]           state_next;
   logic [BIN_W-1:0]     value_q;
   logic                 ctrl_q;
   logic [BIN_W-1:0]     bin_q;
   logic [ACC_W-1:0]     acc_q;
   logic [3:0]           iter_q;
   logic [15:0]          bcd_q;
   logic [15:0]          disp_q;
   logic                 busy_q;
   logic                 ovf_q;
   logic [CNT_W-1:0]     scan_cnt_q;
   logic [DIG_IDX_W-1:0] digit_q;

   logic                 wr_value_c;
   logic                 wr_ctrl_c;
   logic [ACC_W-1:0]     acc_adj_c;
   logic [ACC_W-1:0]     acc_shift_c;
   logic [BIN_W-1:0]     bin_shift_c;
   logic [3:0]           nibble_c;
   logic                 blank_c;
   logic [6:0]           seg_next_c;
   logic [DIGITS-1:0]    dig_next_c;
   logic                 unused_wdata;

   assign wr_value_c   = chipselect & ~write_n & (address == 2'd0);
   assign wr_ctrl_c    = chipselect & ~write_n & (address == 2'd1);
   assign unused_wdata = ^writedata[31:16];
   assign status       = {ovf_q, busy_q};

   // Active-low 7-segment pattern for one BCD digit, bit 0 = segment a
   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // One double-dabble iteration: add 3 to nibbles >= 5, then shift {acc, bin}
   always_comb begin
      acc_adj_c = acc_q;
      for (int i = 0; i < 5; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            acc_adj_c[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
      {acc_shift_c, bin_shift_c} = {acc_adj_c, bin_q} << 1;
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_next;
   end

   // FSM next state; a VALUE write restarts the conversion from any state
   always_comb begin
      state_next = state_q;
      case (state_q)
         ST_IDLE:  state_next = ST_IDLE;
         ST_SHIFT: if (iter_q == 4'd15) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
      if (wr_value_c) state_next = ST_SHIFT;
   end

   // Conversion datapath, result capture and status flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         value_q <= '0;
         bin_q   <= '0;
         acc_q   <= '0;
         iter_q  <= '0;
         bcd_q   <= '0;
         disp_q  <= '0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         busy_q <= (state_next != ST_IDLE);
         if (wr_value_c) begin
            value_q <= writedata[15:0];
            bin_q   <= writedata[15:0];
            acc_q   <= '0;
            iter_q  <= '0;
         end else if (state_q == ST_SHIFT) begin
            acc_q  <= acc_shift_c;
            bin_q  <= bin_shift_c;
            iter_q <= iter_q + 4'd1;
         end else if (state_q == ST_DONE) begin
            bcd_q  <= acc_q[15:0];
            disp_q <= acc_q[15:0];
            ovf_q  <= |acc_q[19:16];
         end
      end
   end

   // CTRL register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       ctrl_q <= 1'b0;
      else if (wr_ctrl_c) ctrl_q <= writedata[0];
   end

   // Registered read mux, sampled every cycle regardless of chipselect
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         case (address)
            2'd0:    readdata <= {16'd0, value_q};
            2'd1:    readdata <= {31'd0, ctrl_q};
            2'd2:    readdata <= {16'd0, bcd_q};
            default: readdata <= '0;
         endcase
      end
   end

   // Scan divider and active digit; keeps running while the display is off
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scan_cnt_q <= '0;
         digit_q    <= '0;
      end else if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
         scan_cnt_q <= '0;
         digit_q    <= digit_q + DIG_IDX_W'(1);
      end else begin
         scan_cnt_q <= scan_cnt_q + CNT_W'(1);
      end
   end

   // Segment/digit selection for the active digit
   always_comb begin
      case (digit_q)
         2'd0:    nibble_c = disp_q[3:0];
         2'd1:    nibble_c = disp_q[7:4];
         2'd2:    nibble_c = disp_q[11:8];
         default: nibble_c = disp_q[15:12];
      endcase
`ifdef BCD_DISPLAY_BLANK_EN
      case (digit_q)
         2'd1:    blank_c = (disp_q[15:4] == 12'd0);
         2'd2:    blank_c = (disp_q[15:8] == 8'd0);
         2'd3:    blank_c = (disp_q[15:12] == 4'd0);
         default: blank_c = 1'b0;
      endcase
`else
      blank_c = 1'b0;
`endif
      if (!ctrl_q)      seg_next_c = 7'h7F;
      else if (ovf_q)   seg_next_c = 7'h3F;
      else if (blank_c) seg_next_c = 7'h7F;
      else              seg_next_c = seg_decode(nibble_c);
      if (ctrl_q) dig_next_c = ~(DIGITS'(1) << digit_q);
      else        dig_next_c = '1;
   end

   // Display outputs registered together so digit and pattern switch in step
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seg_n <= 7'h7F;
         dig_n <= '1;
      end else begin
         seg_n <= seg_next_c;
         dig_n <= dig_next_c;
      end
   end

endmodule

// File: tb/tb_bcd_display_driver.sv
// tb_bcd_display_driver: directed self-checking bench for bcd_display_driver
// (scan divider shortened to 4; expectations follow BCD_DISPLAY_BLANK_EN).
module tb_bcd_display_driver;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [6:0]  seg_n;
   logic [3:0]  dig_n;
   logic [1:0]  status;

   int checks = 0;
   int errors = 0;

   bcd_display_driver #(.SCAN_DIV(4), .DIGITS(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .seg_n      (seg_n),
      .dig_n      (dig_n),
      .status     (status)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; the write is captured on the following posedge
   task automatic do_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic do_read(input logic [1:0] a, output logic [31:0] d);
      address    = a;
      chipselect = 1'b1;
      @(negedge clk);
      d          = readdata;
      chipselect = 1'b0;
   endtask

   task automatic wait_busy(output int n);
      n = 0;
      while (status[0] && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      logic [31:0] d;
      logic [3:0]  exp_dig;
      logic [6:0]  exp_seg;
      logic [6:0]  zero_seg;
      int          n;
      int          cnt;
      int          guard;
      logic        bad;

`ifdef BCD_DISPLAY_BLANK_EN
      zero_seg = 7'h7F;
`else
      zero_seg = 7'h40;
`endif
      reset_n    = 1'b1;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;

      // Asynchronous reset before any clock edge
      #2 reset_n = 1'b0;
      #1;
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_seg", {25'd0, seg_n}, 32'h7F);
      chk("rst_dig", {28'd0, dig_n}, 32'hF);
      chk("rst_status", {30'd0, status}, 32'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Convert 1234: busy for exactly 17 cycles, BCD 0x1234, no overflow
      do_write(2'd0, 32'd1234);
      wait_busy(n);
      chk("busy_len_1234", n, 17);
      chk("ovf_1234", {30'd0, status}, 32'h0);
      do_read(2'd2, d);
      chk("bcd_1234", d, 32'h1234);
      do_read(2'd0, d);
      chk("value_1234", d, 32'd1234);

      // Read latency is exactly one cycle; addr 3 reads 0 and ignores writes
      address = 2'd3;
      @(negedge clk);
      chk("addr3_read", readdata, 32'h0);
      address = 2'd0;
      #1;
      chk("lat_hold", readdata, 32'h0);
      @(negedge clk);
      chk("lat_one", readdata, 32'd1234);
      do_write(2'd3, 32'hFFFF_FFFF);
      do_read(2'd3, d);
      chk("addr3_wr_ignored", d, 32'h0);
      do_read(2'd0, d);
      chk("value_after_addr3", d, 32'd1234);
      do_write(2'd1, 32'h1);
      do_read(2'd1, d);
      chk("ctrl_read", d, 32'h1);

      // 10000 overflows: dashes on every enabled digit
      do_write(2'd0, 32'd10000);
      wait_busy(n);
      chk("busy_len_10000", n, 17);
      chk("ovf_10000", {30'd0, status}, 32'h2);
      do_read(2'd2, d);
      chk("bcd_10000", d, 32'h0);
      repeat (2) @(negedge clk);
      chk("dash_dig_on", {31'd0, dig_n != 4'hF}, 32'h1);
      for (int k = 0; k < 8; k++) begin
         chk("dash_seg", {25'd0, seg_n}, 32'h3F);
         @(negedge clk);
      end

      // 9999 is the largest value without overflow; clears the flag
      do_write(2'd0, 32'd9999);
      wait_busy(n);
      chk("ovf_9999", {30'd0, status}, 32'h0);
      do_read(2'd2, d);
      chk("bcd_9999", d, 32'h9999);

      // VALUE 7: scan E,D,B,7 each for 4 cycles
      do_write(2'd0, 32'd7);
      wait_busy(n);
      chk("ovf_7", {30'd0, status}, 32'h0);
      repeat (2) @(negedge clk);
      guard = 0;
      while (dig_n != 4'h7 && guard < 40) begin
         guard++;
         @(negedge clk);
      end
      while (dig_n == 4'h7 && guard < 40) begin
         guard++;
         @(negedge clk);
      end
      chk("scan_sync_timeout", {31'd0, guard >= 40}, 32'h0);
      for (int k = 0; k < 16; k++) begin
         case (k / 4)
            0:       exp_dig = 4'hE;
            1:       exp_dig = 4'hD;
            2:       exp_dig = 4'hB;
            default: exp_dig = 4'h7;
         endcase
         exp_seg = (k < 4) ? 7'h78 : zero_seg;
         chk("scan_dig", {28'd0, dig_n}, {28'd0, exp_dig});
         chk("scan_seg", {25'd0, seg_n}, {25'd0, exp_seg});
         @(negedge clk);
      end

      // Display disable blanks everything
      do_write(2'd1, 32'h0);
      repeat (2) @(negedge clk);
      chk("off_dig", {28'd0, dig_n}, 32'hF);
      chk("off_seg", {25'd0, seg_n}, 32'h7F);
      do_write(2'd1, 32'h1);
      repeat (2) @(negedge clk);

      // Abort: 1234 then 42 at iteration 8 -> one 25-cycle busy pulse
      cnt = 0;
      bad = 1'b0;
      do_write(2'd0, 32'd1234);
      for (int k = 0; k < 7; k++) begin
         if (status[0]) cnt++;
         if (seg_n inside {7'h79, 7'h24, 7'h30, 7'h19}) bad = 1'b1;
         @(negedge clk);
      end
      if (status[0]) cnt++;
      do_write(2'd0, 32'd42);
      guard = 0;
      while (status[0] && guard < 100) begin
         cnt++;
         guard++;
         if (seg_n inside {7'h79, 7'h24, 7'h30, 7'h19}) bad = 1'b1;
         @(negedge clk);
      end
      chk("abort_busy_len", cnt, 25);
      chk("abort_no_1234_shown", {31'd0, bad}, 32'h0);
      do_read(2'd2, d);
      chk("abort_bcd", d, 32'h0042);
      chk("abort_status", {30'd0, status}, 32'h0);

      // Reset mid-conversion
      do_write(2'd0, 32'd1234);
      address = 2'd0;
      repeat (9) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("midrst_readdata", readdata, 32'h0);
      chk("midrst_seg", {25'd0, seg_n}, 32'h7F);
      chk("midrst_dig", {28'd0, dig_n}, 32'hF);
      chk("midrst_status", {30'd0, status}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_status", {30'd0, status}, 32'h0);
      do_read(2'd2, d);
      chk("post_rst_bcd", d, 32'h0);
      do_read(2'd0, d);
      chk("post_rst_value", d, 32'h0);
      do_read(2'd1, d);
      chk("post_rst_ctrl", d, 32'h0);
      chk("post_rst_dig", {28'd0, dig_n}, 32'hF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_display_driver.md
BCD_DISPLAY_DRIVER -- requirements
Module: bcd_display_driver

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles per digit-scan step, legal range 2..2^20.
REQ-002 Parameter DIGITS, fixed 4: number of multiplexed 7-segment digits.
REQ-003 Port clk, input, 1: single clock for all logic.
REQ-004 Port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port address, input, 2: Avalon-MM slave word address.
REQ-006 Port chipselect, input, 1: slave select.
REQ-007 Port write_n, input, 1: active-low write strobe.
REQ-008 Port writedata, input, 32: write data.
REQ-009 Port readdata, output, 32: registered read data.
REQ-010 Port seg_n, output, 7: segments a..g, active-low; bit 0 = a.
REQ-011 Port dig_n, output, 4: digit enables, active-low, one-hot-low; bit 0 = least significant digit.
REQ-012 Port status, output, 2: bit 0 = busy, bit 1 = overflow; feeds the downstream edge-capture status PIO.

Function
REQ-013 Register map: addr 0 VALUE (R/W, 16 LSBs used); addr 1 CTRL (R/W, bit 0 = display enable); addr 2 BCD (RO, 16-bit packed result); addr 3 reads 0, writes ignored.
REQ-014 readdata SHALL be registered every cycle from address, independent of chipselect, with one-cycle latency; unused bits are 0.
REQ-015 A write to VALUE at cycle N SHALL load VALUE, clear the shift datapath and enter state SHIFT at N+1.
REQ-016 FSM states: IDLE, SHIFT, DONE. IDLE->SHIFT on a VALUE write; SHIFT runs exactly 16 double-dabble iterations, one per cycle; SHIFT->DONE after the 16th; DONE->IDLE after one cycle.
REQ-017 Each iteration adds 3 to every BCD nibble >= 5, then shifts {bcd, bin} left by 1; the BCD accumulator is 20 bits wide, so it cannot truncate before the range check.
REQ-018 In DONE the packed low 16 BCD bits SHALL be copied into the display register and the BCD register; these update at no other time.
REQ-019 busy SHALL be 1 in SHIFT and DONE (17 cycles, N+1..N+17), otherwise 0.
REQ-020 overflow SHALL be set in DONE if VALUE > 9999 and cleared in DONE otherwise; it holds between conversions.
REQ-021 While overflow = 1, every digit SHALL display a dash (only segment g lit).
REQ-022 A VALUE write during SHIFT or DONE SHALL abort the conversion and restart at iteration 0 with the new value; the display register keeps its old contents; busy stays 1 without a gap.
REQ-023 A scan counter SHALL count 0..SCAN_DIV-1 and, on wrap, advance the active digit 0->1->2->3->0.
REQ-024 When CTRL bit 0 = 0, dig_n = 4'b1111 and seg_n = 7'h7F; the scan counter keeps running.
REQ-025 seg_n and dig_n SHALL be registered outputs, and digit and segment pattern SHALL change in the same cycle.

Reset
REQ-026 On reset_n = 0 these values apply asynchronously: readdata = 0, VALUE = 0, CTRL = 0, BCD and display register = 0, FSM = IDLE, status = 2'b00, scan counter = 0, active digit = 0, seg_n = 7'h7F, dig_n = 4'hF.
REQ-027 Reset during SHIFT SHALL discard the conversion with no display update; after release the block is IDLE.

Configuration
REQ-028 Macro BCD_DISPLAY_BLANK_EN defined: leading zero digits SHALL be blanked (seg_n = 7'h7F, digit still scanned), and digit 0 always shows. Macro undefined: all four digits always show, including leading zeros. Overflow dashes are not blanked in either case.

Verification
REQ-029 Write VALUE = 1234 at cycle N -> busy 1 over N+1..N+17; BCD reads 16'h1234 after N+17; overflow = 0.
REQ-030 Write VALUE = 10000 -> overflow = 1 after DONE; all enabled digits show seg_n = 7'h3F (dash).
REQ-031 Write 1234, then write 0042 at iteration 8 -> single continuous busy pulse of 8 + 17 cycles; BCD = 16'h0042; display never shows 1234.
REQ-032 SCAN_DIV = 4, CTRL = 1, VALUE = 7 -> dig_n cycles E,D,B,7 every 4 cycles; with BLANK_EN digits 1..3 have seg_n = 7'h7F; without BLANK_EN they show the "0" pattern.
REQ-033 Assert reset_n at iteration 10 -> all outputs reach their reset values immediately; after release, status = 0 and BCD = 0.
REQ-034 Read each address with chipselect = 1 -> data appears exactly one cycle later; addr 3 returns 0.
